instr_word_packer: RTL and testbench
====================================

// Module: instr_word_packer
// PURPOSE
//  Inverse of the instruction field splitter: packs MIPS32 fields (R/I/J format) into 32-bit words.
//  Buffers the words in a small FIFO and streams them to instruction-memory write port at consecutive
//  word addresses. Used by the program loader / test harness to fill IMEM before the core runs.
// PARAMETERS
//  DEPTH      4             FIFO entries; power of two, >= 2
//  BASE_ADDR  32'h00000000  first byte address written after reset/flush; must be word aligned
// PORTS
//  clk       in   1   single clock, all state on rising edge
//  reset     in   1   asynchronous, active-high; clears all state
//  flush     in   1   synchronous clear: FIFO, address counter, err
//  in_valid  in   1   field bundle valid
//  in_ready  out  1   packer can accept bundle (FIFO not full)
//  fmt       in   2   00=R, 01=I, 10=J, 11=illegal
//  opcode    in   6   word[31:26], all formats
//  rs        in   5   R/I word[25:21]
//  rt        in   5   R/I word[20:16]
//  rd        in   5   R word[15:11]
//  shamt     in   5   R word[10:6]
//  funct     in   6   R word[5:0]
//  imm       in   16  I word[15:0]
//  target    in   26  J word[25:0]
//  wr_en     out  1   head word valid toward IMEM (FIFO not empty)
//  wr_ready  in   1   IMEM accepts word this cycle
//  wr_addr   out  32  byte address of head word
//  wr_data   out  32  packed head word
//  count     out  $clog2(DEPTH)+1  FIFO occupancy
//  err       out  1   sticky: illegal fmt received
// BEHAVIOUR
//  - Reset: in_ready=1, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, count=0, err=0; reset mid-transfer
//    discards all buffered words, none written.
//  - Packing: R={opcode,rs,rt,rd,shamt,funct}; I={opcode,rs,rt,imm}; J={opcode,target};
//    fields not used by the format are ignored.
//  - Push: in_valid&&in_ready. in_ready = (count<DEPTH); registered, no combinational path from
//    wr_ready, so full FIFO refuses input even when a pop occurs that cycle.
//  - Illegal fmt (11): handshake completes, nothing pushed, err<=1 (held until reset/flush).
//  - Latency: word accepted at edge N is visible on wr_data/wr_en from cycle N+1 if FIFO was empty.
//  - Pop: wr_en&&wr_ready; head advances, wr_addr += 4 (mod 2^32, wraps 0xFFFFFFFC->0x00000000).
//    wr_addr/wr_data stable while wr_en=1 and wr_ready=0. wr_data checked only when wr_en=1.
//  - Push+pop same cycle (0<count<DEPTH): count unchanged, order preserved.
//  - Pointers wrap modulo DEPTH; count distinguishes full (DEPTH) from empty (0).
//  - Flush: next cycle count=0, wr_en=0, wr_addr=BASE_ADDR, err=0; a push or pop coinciding with
//    flush is discarded / not counted (flush wins).
//  - No state machine beyond FIFO; control = count, rd/wr pointers, address counter.
// TESTING
//  1 R add: fmt=00 op=0 rs=1 rt=2 rd=3 shamt=0 funct=0x20, wr_ready=1 -> next cycle wr_en=1,
//    wr_data=0x00221820, wr_addr=0x00000000; following cycle wr_addr=0x00000004, wr_en=0.
//  2 I/J: addi op=8 rs=0 rt=8 imm=5 -> 0x20080005; j op=2 target=0x0100000 -> 0x08100000,
//    written at consecutive addresses 0x0,0x4.
//  3 Backpressure: wr_ready=0, push 5 words (DEPTH=4) -> in_ready=0 after 4th, count=4, 5th held;
//    then wr_ready=1 -> words drained in order, addresses 0x0..0xC, 5th accepted, ends at 0x10.
//  4 Illegal fmt=11 between two legal pushes -> only 2 words written, err=1 until flush.
//  5 Flush with count=3 and simultaneous push -> next cycle count=0, wr_en=0, wr_addr=BASE_ADDR,
//    err=0; async reset asserted mid-burst -> outputs at reset values immediately.
//  6 Wrap: BASE_ADDR=32'hFFFFFFF8, push 3 words -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/instr_word_packer.sv
// -----------------------------------------------------------------------------
// instr_word_packer
//
// Packs MIPS32 instruction fields (R, I or J format) into 32-bit words.
// The words are buffered in a small FIFO and streamed to an instruction-memory
// write port at consecutive word addresses. The program loader / test harness
// uses it to fill IMEM before the core runs.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 2)
//   BASE_ADDR  first byte address written after reset/flush (word aligned)
//
// Ports
//   clk       in   single clock, all state on rising edge
//   reset     in   asynchronous active-high clear of all state
//   flush     in   synchronous clear of FIFO, address counter and err
//   in_valid  in   field bundle valid
//   in_ready  out  bundle can be accepted (registered, FIFO not full)
//   fmt       in   00=R, 01=I, 10=J, 11=illegal
//   opcode    in   word[31:26]
//   rs, rt    in   R/I word[25:21], word[20:16]
//   rd, shamt in   R word[15:11], word[10:6]
//   funct     in   R word[5:0]
//   imm       in   I word[15:0]
//   target    in   J word[25:0]
//   wr_en     out  head word valid toward IMEM
//   wr_ready  in   IMEM accepts the head word this cycle
//   wr_addr   out  byte address of head word
//   wr_data   out  packed head word (zero while FIFO empty)
//   count     out  FIFO occupancy
//   err       out  sticky flag: illegal fmt was received
// -----------------------------------------------------------------------------
module instr_word_packer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               fmt,
  input  logic [5:0]               opcode,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               shamt,
  input  logic [5:0]               funct,
  input  logic [15:0]              imm,
  input  logic [25:0]              target,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [31:0]              wr_addr,
  output logic [31:0]              wr_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic [31:0]   addr_q;
  logic          err_q;
  logic          ready_q;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   packed_word;

  // Assemble the instruction word; fields unused by the format are ignored.
  always_comb begin
    packed_word = 32'h0;
    case (fmt)
      2'b00:   packed_word = {opcode, rs, rt, rd, shamt, funct};
      2'b01:   packed_word = {opcode, rs, rt, imm};
      2'b10:   packed_word = {opcode, target};
      default: packed_word = 32'h0;
    endcase
  end

  // An illegal bundle still completes its handshake but is never stored.
  assign accept = in_valid && ready_q;
  assign push   = accept && (fmt != 2'b11);
  assign pop    = (count_q != '0) && wr_ready;

  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // Control state. in_ready is registered from the next occupancy so that a
  // full FIFO refuses input even in a cycle where a pop happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        addr_q <= addr_q + 32'd4;
      end
      if (accept && (fmt == 2'b11)) begin
        err_q <= 1'b1;
      end
      count_q <= count_next;
      ready_q <= (count_next != FULL);
    end
  end

  // Storage needs no reset: entries are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= packed_word;
    end
  end

  assign in_ready = ready_q;
  assign wr_en    = (count_q != '0);
  assign wr_addr  = addr_q;
  assign wr_data  = wr_en ? mem[rd_ptr] : 32'h0;
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_word_packer.sv
module tb_instr_word_packer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        wr_en;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  count;
  logic        err;

  instr_word_packer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: occupancy, head address, sticky error, and a scoreboard
  // of {address, word} pairs in the order they must reach IMEM.
  int          model_count;
  logic [31:0] model_addr;
  logic [31:0] push_addr;
  bit          model_err;
  logic [63:0] exp_q[$];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Word value computed from the field layout as plain weighted sums.
  function automatic logic [31:0] model_word(input logic [1:0] f);
    logic [31:0] w;
    case (f)
      2'b00: w = 32'(opcode) * 32'h0400_0000 + 32'(rs) * 32'h0020_0000 + 32'(rt) * 32'h0001_0000
               + 32'(rd) * 32'h800 + 32'(shamt) * 32'h40 + 32'(funct);
      2'b01: w = 32'(opcode) * 32'h0400_0000 + 32'(rs) * 32'h0020_0000 + 32'(rt) * 32'h0001_0000
               + 32'(imm);
      default: w = 32'(opcode) * 32'h0400_0000 + 32'(target);
    endcase
    return w;
  endfunction

  task automatic model_clear();
    model_count = 0;
    model_addr  = BASE;
    push_addr   = BASE;
    model_err   = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: check status mid-cycle, advance the model at the edge,
  // then return just after the edge so the caller can drive new inputs.
  task automatic step();
    bit do_pop;
    bit do_acc;
    @(negedge clk);
    if (!reset) begin
      check_output("count", 32'(count), 32'(model_count));
      check_output("in_ready", 32'(in_ready), 32'(model_count < DEPTH));
      check_output("wr_en", 32'(wr_en), 32'(model_count > 0));
      check_output("wr_addr", wr_addr, model_addr);
      check_output("err", 32'(err), 32'(model_err));
    end
    @(posedge clk);
    if (reset || flush) begin
      model_clear();
    end else begin
      do_pop = (model_count > 0) && wr_ready;
      do_acc = in_valid && (model_count < DEPTH);
      if (do_acc) begin
        if (fmt == 2'b11) begin
          model_err = 1'b1;
        end else begin
          exp_q.push_back({push_addr, model_word(fmt)});
          push_addr += 32'd4;
          model_count++;
        end
      end
      if (do_pop) begin
        model_count--;
        model_addr += 32'd4;
      end
    end
    #1;
  endtask

  // Monitor: every word IMEM takes must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset === 1'b0 && wr_en === 1'b1 && wr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_word actual=0x%08h@0x%08h expected=none", wr_data, wr_addr);
      end else begin
        e = exp_q.pop_front();
        check_output("mon_wr_data", wr_data, e[31:0]);
        check_output("mon_wr_addr", wr_addr, e[63:32]);
      end
    end
  end

  task automatic set_idle();
    in_valid = 1'b0; fmt = 2'b00;
    opcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
  endtask

  // Random contents in every field so unused ones are exercised as garbage.
  task automatic apply_stimulus(input logic [1:0] f);
    in_valid = 1'b1; fmt = f;
    opcode = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    shamt = 5'($urandom); funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
  endtask

  initial begin
    bit done;
    reset = 1'b1; flush = 1'b0; wr_ready = 1'b0;
    set_idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_wr_en", 32'(wr_en), 32'd0);
    check_output("rst_wr_addr", wr_addr, BASE);
    check_output("rst_wr_data", wr_data, 32'h0);
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    step();

    // R-format add, visible one cycle after acceptance.
    $display("[TB] R add");
    wr_ready = 1'b1;
    set_idle(); in_valid = 1'b1; fmt = 2'b00; rs = 5'd1; rt = 5'd2; rd = 5'd3; funct = 6'h20;
    step();
    set_idle();
    check_output("r_add_word", wr_data, 32'h0022_1820);
    check_output("r_add_addr", wr_addr, BASE);
    step();
    step();

    // I then J format, written back to back across the address wrap.
    $display("[TB] I and J");
    set_idle(); in_valid = 1'b1; fmt = 2'b01; rt = 5'd8; opcode = 6'd8; imm = 16'd5; rd = 5'd31;
    step();
    check_output("addi_word", wr_data, 32'h2008_0005);
    set_idle(); in_valid = 1'b1; fmt = 2'b10; opcode = 6'd2; target = 26'h010_0000; imm = 16'hFFFF;
    step();
    check_output("j_word", wr_data, 32'h0810_0000);
    set_idle();
    repeat (3) step();

    // Backpressure: fill the FIFO, hold the fifth, then drain.
    $display("[TB] backpressure");
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2'($urandom_range(0, 2)));
      step();
    end
    apply_stimulus(2'b00);
    step();
    step();
    check_output("full_count", 32'(count), 32'd4);
    check_output("full_in_ready", 32'(in_ready), 32'd0);
    wr_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      if (model_count < DEPTH) done = 1'b1;
      step();
    end
    check_output("fifth_accepted", 32'(done), 32'd1);
    set_idle();
    repeat (6) step();

    // Illegal format between two legal pushes.
    $display("[TB] illegal fmt");
    apply_stimulus(2'b01); step();
    apply_stimulus(2'b11); step();
    apply_stimulus(2'b10); step();
    set_idle();
    repeat (4) step();
    check_output("err_sticky", 32'(err), 32'd1);

    // Flush with three words buffered and a simultaneous push.
    $display("[TB] flush");
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(2'($urandom_range(0, 2)));
      step();
    end
    apply_stimulus(2'b00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_idle();
    check_output("flush_count", 32'(count), 32'd0);
    check_output("flush_wr_en", 32'(wr_en), 32'd0);
    check_output("flush_err", 32'(err), 32'd0);
    check_output("flush_addr", wr_addr, BASE);
    step();

    // Asynchronous reset in the middle of a burst.
    $display("[TB] async reset");
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(2'($urandom_range(0, 2)));
      step();
    end
    set_idle();
    #2 reset = 1'b1;
    #1;
    check_output("areset_wr_en", 32'(wr_en), 32'd0);
    check_output("areset_count", 32'(count), 32'd0);
    check_output("areset_in_ready", 32'(in_ready), 32'd1);
    check_output("areset_wr_addr", wr_addr, BASE);
    check_output("areset_wr_data", wr_data, 32'h0);
    step();
    reset = 1'b0;
    wr_ready = 1'b1;
    step();

    // Address wrap: three words starting below 2^32.
    $display("[TB] wrap");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(2'($urandom_range(0, 2)));
      step();
    end
    set_idle();
    check_output("wrap_addr", wr_addr, 32'h0000_0000);
    repeat (3) step();

    // Random traffic with occasional flushes and illegal formats.
    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 6) apply_stimulus(2'($urandom));
      else set_idle();
      wr_ready = 1'($urandom);
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
    flush = 1'b0;
    set_idle();
    wr_ready = 1'b1;
    repeat (DEPTH + 4) step();
    check_output("drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
